// File: rtl/wash_phase_timer.sv
// ---------------------------------------------------------------------------
// wash_phase_timer
//
// Timing and rinse-count stage in front of the washing machine control FSM.
// It watches the FSM's actuator outputs to tell when a wash or a spin is
// running. It times each phase with a prescaled seconds counter and returns
// the cycleTO, spinTO and againwash inputs the FSM waits on. It also exports
// the ticks remaining for the front-panel display.
//
// Parameters
//   CLK_DIV    clk cycles per timer tick (>= 2)
//   CYCLE_SEC  ticks per wash/rinse cycle (>= 1)
//   SPIN_SEC   ticks per spin (>= 1)
//   TIME_W     seconds counter width, must hold max(CYCLE_SEC, SPIN_SEC)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high
//   motor_on      FSM actuator output
//   water_wash    FSM actuator output
//   drain_val_on  FSM actuator output
//   done          FSM one-cycle completion pulse (clears the wash count)
//   rinse_cfg     extra rinse cycles requested (0-3)
//   cycleTO       wash-cycle timeout to the FSM
//   spinTO        spin timeout to the FSM
//   againwash     another fill/wash is still owed
//   sec_tick      one-cycle pulse per timer tick
//   time_left     ticks remaining in the current timed phase
//   phase         0 idle, 1 wash, 2 spin, 3 timed-out
//
// All outputs are registered. Each output is computed from the next-state
// values, so it changes on the same edge as the state it describes.
// ---------------------------------------------------------------------------
module wash_phase_timer #(
  parameter int CLK_DIV   = 1000,
  parameter int CYCLE_SEC = 10,
  parameter int SPIN_SEC  = 5,
  parameter int TIME_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              motor_on,
  input  logic              water_wash,
  input  logic              drain_val_on,
  input  logic              done,
  input  logic [1:0]        rinse_cfg,
  output logic              cycleTO,
  output logic              spinTO,
  output logic              againwash,
  output logic              sec_tick,
  output logic [TIME_W-1:0] time_left,
  output logic [1:0]        phase
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX    = PRE_W'(CLK_DIV - 1);
  localparam logic [TIME_W-1:0] CYCLE_LOAD = TIME_W'(CYCLE_SEC);
  localparam logic [TIME_W-1:0] SPIN_LOAD  = TIME_W'(SPIN_SEC);
  localparam logic [TIME_W-1:0] CNT_ONE    = TIME_W'(1);

  typedef enum logic [2:0] {
    T_IDLE,
    T_WASH,
    T_WASH_TO,
    T_SPIN,
    T_SPIN_TO
  } state_t;

  state_t            state_reg, state_next;
  logic [PRE_W-1:0]  presc_reg, presc_next;
  logic [TIME_W-1:0] cnt_reg, cnt_next;
  logic [1:0]        washes_reg, washes_next;
  logic [1:0]        cfg_reg, cfg_next;

  logic              cycle_to_reg, cycle_to_next;
  logic              spin_to_reg, spin_to_next;
  logic              againwash_reg, againwash_next;
  logic              sec_tick_reg, sec_tick_next;
  logic [TIME_W-1:0] time_left_reg, time_left_next;
  logic [1:0]        phase_reg, phase_next;

  logic wash_act;
  logic spin_act;
  logic tick;
  logic load;

  always_comb begin
    wash_act = motor_on & water_wash;
    spin_act = motor_on & ~water_wash & ~drain_val_on;
    tick     = (presc_reg == PRE_MAX);

    state_next  = state_reg;
    cnt_next    = cnt_reg;
    washes_next = washes_reg;
    cfg_next    = cfg_reg;
    load        = 1'b0;

    case (state_reg)
      T_IDLE: begin
        // Wash wins if both decodes are high. The rinse setting is only
        // sampled at the start of a fresh program (no washes counted yet).
        if (wash_act) begin
          state_next = T_WASH;
          cnt_next   = CYCLE_LOAD;
          load       = 1'b1;
          if (washes_reg == 2'd0) begin
            cfg_next = rinse_cfg;
          end
        end else if (spin_act) begin
          state_next = T_SPIN;
          cnt_next   = SPIN_LOAD;
          load       = 1'b1;
        end
      end

      T_WASH: begin
        // A drop on the same edge as the final tick counts as an abort.
        if (!wash_act) begin
          state_next = T_IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_ONE) begin
            state_next = T_WASH_TO;
            cnt_next   = '0;
            if (washes_reg != 2'd3) begin
              washes_next = washes_reg + 2'd1;
            end
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
      end

      T_WASH_TO: begin
        if (!water_wash) begin
          state_next = T_IDLE;
        end
      end

      T_SPIN: begin
        if (!spin_act) begin
          state_next = T_IDLE;
          cnt_next   = '0;
        end else if (tick) begin
          if (cnt_reg == CNT_ONE) begin
            state_next = T_SPIN_TO;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_ONE;
          end
        end
      end

      T_SPIN_TO: begin
        // End of spin closes the program, so the wash count restarts.
        if (done || !motor_on) begin
          state_next  = T_IDLE;
          washes_next = 2'd0;
        end
      end

      default: begin
        state_next = T_IDLE;
        cnt_next   = '0;
      end
    endcase

    if (done) begin
      washes_next = 2'd0;
    end

    // Restarting the prescaler on a load makes every phase exactly
    // SEC * CLK_DIV cycles long. A tick that lands on the load edge is
    // swallowed, both for the countdown and for the sec_tick output.
    if (load || tick) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + PRE_W'(1);
    end

    sec_tick_next = tick & ~load;
    cycle_to_next = (state_next == T_WASH_TO);
    spin_to_next  = (state_next == T_SPIN_TO);

    if ((state_next == T_WASH) || (state_next == T_SPIN)) begin
      time_left_next = cnt_next;
    end else begin
      time_left_next = '0;
    end

    case (state_next)
      T_WASH:               phase_next = 2'd1;
      T_SPIN:               phase_next = 2'd2;
      T_WASH_TO, T_SPIN_TO: phase_next = 2'd3;
      default:              phase_next = 2'd0;
    endcase

    // Total washes owed = 1 + cfg; widened to 3 bits so cfg=3 cannot wrap.
    againwash_next = ({1'b0, washes_next} < ({1'b0, cfg_next} + 3'd1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= T_IDLE;
      presc_reg     <= '0;
      cnt_reg       <= '0;
      washes_reg    <= 2'd0;
      cfg_reg       <= 2'd0;
      cycle_to_reg  <= 1'b0;
      spin_to_reg   <= 1'b0;
      againwash_reg <= 1'b1;
      sec_tick_reg  <= 1'b0;
      time_left_reg <= '0;
      phase_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      cnt_reg       <= cnt_next;
      washes_reg    <= washes_next;
      cfg_reg       <= cfg_next;
      cycle_to_reg  <= cycle_to_next;
      spin_to_reg   <= spin_to_next;
      againwash_reg <= againwash_next;
      sec_tick_reg  <= sec_tick_next;
      time_left_reg <= time_left_next;
      phase_reg     <= phase_next;
    end
  end

  assign cycleTO   = cycle_to_reg;
  assign spinTO    = spin_to_reg;
  assign againwash = againwash_reg;
  assign sec_tick  = sec_tick_reg;
  assign time_left = time_left_reg;
  assign phase     = phase_reg;

endmodule

// File: tb/tb_wash_phase_timer.sv
// ---------------------------------------------------------------------------
// tb_wash_phase_timer
//
// Directed bench for wash_phase_timer with CLK_DIV=4, CYCLE_SEC=3,
// SPIN_SEC=2. A behavioural model tracks the phase, how many clk edges have
// passed since the prescaler last restarted, and the wash count. Every output
// follows from that by arithmetic. The model is compared against the DUT two
// time units after every rising edge. Literal expectations at key points of
// each scenario pin the model itself. Inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_wash_phase_timer;

  localparam int CLK_DIV   = 4;
  localparam int CYCLE_SEC = 3;
  localparam int SPIN_SEC  = 2;
  localparam int TIME_W    = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              motor_on = 1'b0;
  logic              water_wash = 1'b0;
  logic              drain_val_on = 1'b0;
  logic              done = 1'b0;
  logic [1:0]        rinse_cfg = 2'd0;
  logic              cycleTO;
  logic              spinTO;
  logic              againwash;
  logic              sec_tick;
  logic [TIME_W-1:0] time_left;
  logic [1:0]        phase;

  int checks = 0;
  int fails  = 0;

  wash_phase_timer #(
    .CLK_DIV  (CLK_DIV),
    .CYCLE_SEC(CYCLE_SEC),
    .SPIN_SEC (SPIN_SEC),
    .TIME_W   (TIME_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .motor_on    (motor_on),
    .water_wash  (water_wash),
    .drain_val_on(drain_val_on),
    .done        (done),
    .rinse_cfg   (rinse_cfg),
    .cycleTO     (cycleTO),
    .spinTO      (spinTO),
    .againwash   (againwash),
    .sec_tick    (sec_tick),
    .time_left   (time_left),
    .phase       (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_phase: 0 idle, 1 washing, 2 spinning, 3 timed out (m_spin says which)
  // m_e    : clk edges since the prescaler last restarted
  int m_phase  = 0;
  bit m_spin   = 1'b0;
  int m_e      = 0;
  int m_washes = 0;
  int m_cfg    = 0;
  bit m_tick   = 1'b0;

  task automatic model_reset();
    m_phase  = 0;
    m_spin   = 1'b0;
    m_e      = 0;
    m_washes = 0;
    m_cfg    = 0;
    m_tick   = 1'b0;
  endtask

  task automatic model_edge();
    bit wa, sa, tk, ld;
    wa = motor_on && water_wash;
    sa = motor_on && !water_wash && !drain_val_on;
    tk = (m_e % CLK_DIV) == (CLK_DIV - 1);
    ld = 1'b0;
    case (m_phase)
      0: begin
        if (wa) begin
          m_phase = 1; m_spin = 1'b0; ld = 1'b1;
          if (m_washes == 0) m_cfg = int'(rinse_cfg);
        end else if (sa) begin
          m_phase = 2; m_spin = 1'b1; ld = 1'b1;
        end
      end
      1: begin
        if (!wa) m_phase = 0;
        else if (m_e + 1 == CYCLE_SEC * CLK_DIV) begin
          m_phase  = 3;
          m_washes = (m_washes < 3) ? m_washes + 1 : 3;
        end
      end
      2: begin
        if (!sa) m_phase = 0;
        else if (m_e + 1 == SPIN_SEC * CLK_DIV) m_phase = 3;
      end
      default: begin
        if (!m_spin) begin
          if (!water_wash) m_phase = 0;
        end else if (done || !motor_on) begin
          m_phase  = 0;
          m_washes = 0;
        end
      end
    endcase
    if (done) m_washes = 0;
    m_tick = tk && !ld;
    m_e    = ld ? 0 : m_e + 1;
  endtask

  function automatic int exp_time_left();
    if (m_phase == 1) return CYCLE_SEC - m_e / CLK_DIV;
    if (m_phase == 2) return SPIN_SEC - m_e / CLK_DIV;
    return 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("cmp_phase",     phase,     m_phase);
      check("cmp_time_left", time_left, exp_time_left());
      check("cmp_sec_tick",  sec_tick,  m_tick);
      check("cmp_cycleTO",   cycleTO,   (m_phase == 3) && !m_spin);
      check("cmp_spinTO",    spinTO,    (m_phase == 3) && m_spin);
      check("cmp_againwash", againwash, m_washes < m_cfg + 1);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    edges(3);
    check("rst_cycleTO",   cycleTO,   0);
    check("rst_spinTO",    spinTO,    0);
    check("rst_sec_tick",  sec_tick,  0);
    check("rst_time_left", time_left, 0);
    check("rst_phase",     phase,     0);
    check("rst_againwash", againwash, 1);
    reset = 1'b0;
    edges(1);

    // Full wash: ticks at 4, 8, 12; timeout at 12; exit one edge after drop.
    motor_on = 1'b1; water_wash = 1'b1;
    edges(1);
    check("t1_e0_phase", phase, 1);
    check("t1_e0_tl",    time_left, 3);
    edges(3);
    check("t1_e3_tick",  sec_tick, 0);
    check("t1_e3_tl",    time_left, 3);
    edges(1);
    check("t1_e4_tick",  sec_tick, 1);
    check("t1_e4_tl",    time_left, 2);
    edges(4);
    check("t1_e8_tick",  sec_tick, 1);
    check("t1_e8_tl",    time_left, 1);
    edges(3);
    check("t1_e11_cto",  cycleTO, 0);
    edges(1);
    check("t1_e12_cto",  cycleTO, 1);
    check("t1_e12_ph",   phase, 3);
    check("t1_e12_tl",   time_left, 0);
    check("t1_e12_aw",   againwash, 0);
    edges(2);
    water_wash = 1'b0; motor_on = 1'b0;
    edges(1);
    check("t1_e15_cto",  cycleTO, 0);
    check("t1_e15_ph",   phase, 0);
    done = 1'b1;
    edges(1);
    done = 1'b0;
    check("t1_done_aw",  againwash, 1);

    // One extra rinse: two washes owed; rinse_cfg change mid-program ignored.
    rinse_cfg = 2'd1; motor_on = 1'b1; water_wash = 1'b1;
    edges(1);
    rinse_cfg = 2'd3;
    edges(12);
    check("t2_w1_cto",   cycleTO, 1);
    check("t2_w1_aw",    againwash, 1);
    motor_on = 1'b0; water_wash = 1'b0;
    edges(1);
    motor_on = 1'b1; water_wash = 1'b1;
    edges(13);
    check("t2_w2_cto",   cycleTO, 1);
    check("t2_w2_aw",    againwash, 0);
    motor_on = 1'b0; water_wash = 1'b0;
    edges(1);
    check("t2_idle_aw",  againwash, 0);
    done = 1'b1;
    edges(1);
    done = 1'b0;
    check("t2_done_aw",  againwash, 1);

    // Wash then spin straight after; spin timeout and done clear the count.
    rinse_cfg = 2'd0; motor_on = 1'b1; water_wash = 1'b1;
    edges(13);
    check("t3_wash_aw",  againwash, 0);
    water_wash = 1'b0;
    edges(1);
    check("t3_idle_ph",  phase, 0);
    edges(1);
    check("t3_s0_ph",    phase, 2);
    check("t3_s0_tl",    time_left, 2);
    edges(7);
    check("t3_s7_sto",   spinTO, 0);
    edges(1);
    check("t3_s8_sto",   spinTO, 1);
    check("t3_s8_ph",    phase, 3);
    edges(2);
    done = 1'b1;
    edges(1);
    done = 1'b0; motor_on = 1'b0;
    check("t3_s11_sto",  spinTO, 0);
    check("t3_s11_ph",   phase, 0);
    check("t3_s11_aw",   againwash, 1);

    // Abort at time_left=2, restart reloads; then drop on the final tick.
    motor_on = 1'b1; water_wash = 1'b1;
    edges(6);
    check("t4_e5_tl",    time_left, 2);
    motor_on = 1'b0;
    edges(1);
    check("t4_ab_ph",    phase, 0);
    check("t4_ab_cto",   cycleTO, 0);
    check("t4_ab_aw",    againwash, 1);
    motor_on = 1'b1;
    edges(1);
    check("t4_re_tl",    time_left, 3);
    edges(11);
    motor_on = 1'b0;
    edges(1);
    check("t4_race_cto", cycleTO, 0);
    check("t4_race_ph",  phase, 0);
    edges(1);

    // Asynchronous reset in the middle of a wash, then a full-length restart.
    motor_on = 1'b1; water_wash = 1'b1;
    edges(9);
    reset = 1'b1;
    #1;
    check("t5_rst_ph",   phase, 0);
    check("t5_rst_tl",   time_left, 0);
    check("t5_rst_cto",  cycleTO, 0);
    check("t5_rst_aw",   againwash, 1);
    edges(1);
    reset = 1'b0;
    edges(1);
    check("t5_re_tl",    time_left, 3);
    edges(11);
    check("t5_e11_cto",  cycleTO, 0);
    edges(1);
    check("t5_e12_cto",  cycleTO, 1);
    motor_on = 1'b0; water_wash = 1'b0;
    edges(2);

    // Wash decode with drain also high still starts a wash.
    motor_on = 1'b1; water_wash = 1'b1; drain_val_on = 1'b1;
    edges(1);
    check("t6_ph",       phase, 1);
    check("t6_tl",       time_left, 3);
    motor_on = 1'b0; water_wash = 1'b0; drain_val_on = 1'b0;
    edges(3);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
